aes_subbytes_sequencer: RTL and testbench

- Byte-serial controller that sequences one shared combinational AES S-box (the existing sub_bytes datapath) over a full 128-bit AES state.
- Collects 16 state bytes over an 8-bit valid/ready stream, then drives the S-box one byte per cycle and writes the results back in place.
- Streams the 16 result bytes out, optionally in ShiftRows order.
- Sits between the 8-bit pad interface and the round logic in the tt_um AES top level.

---
 rtl/aes_subbytes_sequencer.sv | 117 +++++++++++
 tb/tb_aes_subbytes_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_sequencer.sv
// Byte-serial SubBytes sequencer: loads 16 state bytes, runs them one per cycle
// through a shared external S-box in place, then streams them out (optionally ShiftRows order).
module aes_subbytes_sequencer #(
    parameter bit SHIFT_ROWS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] sbox_in,
    input  logic [7:0] sbox_out,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       block_done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SUB   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic [7:0] buf_q [16];
    logic       wr_en;
    logic [7:0] wr_dat;
    logic [1:0] src_col;
    logic [3:0] src_idx;

    // ShiftRows: row r of output column c comes from input column (c + r) mod 4.
    always_comb begin
        src_col = idx_q[3:2] + idx_q[1:0];
        src_idx = SHIFT_ROWS ? {src_col, idx_q[1:0]} : idx_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        wr_dat    = in_data;
        in_ready  = 1'b0;
        sbox_in   = 8'h00;
        out_data  = 8'h00;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en  = 1'b1;
                    wr_dat = in_data;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = SUB;
                        idx_d   = 4'd0;
                    end
                end
            end
            SUB: begin
                busy    = 1'b1;
                sbox_in = buf_q[idx_q];
                wr_en   = 1'b1;
                wr_dat  = sbox_out;
                idx_d   = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = DRAIN;
                    idx_d   = 4'd0;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = buf_q[src_idx];
                if (out_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = LOAD;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Buffer contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            buf_q[idx_q] <= wr_dat;
        end
    end

    assign block_done = done_q;

endmodule

// File: tb/tb_aes_subbytes_sequencer.sv
// Directed bench for aes_subbytes_sequencer: two instances (ShiftRows on/off) share one
// input stream, each backed by a behavioural S-box.
module tb_aes_subbytes_sequencer;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb8145ede0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int pos;
        pos = 2047 - 8 * int'(x);
        return SBOX_TAB[pos -: 8];
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready, out_valid, busy, block_done;
    logic [7:0] sbox_in, sbox_out, out_data;
    logic       in_ready0, out_valid0, busy0, block_done0;
    logic [7:0] sbox_in0, sbox_out0, out_data0;

    assign sbox_out  = sbox(sbox_in);
    assign sbox_out0 = sbox(sbox_in0);

    aes_subbytes_sequencer #(.SHIFT_ROWS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sbox_in(sbox_in), .sbox_out(sbox_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .block_done(block_done)
    );

    aes_subbytes_sequencer #(.SHIFT_ROWS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .sbox_in(sbox_in0), .sbox_out(sbox_out0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .busy(busy0), .block_done(block_done0)
    );

    always #5 clk = ~clk;

    int nassert = 0;
    int nfail   = 0;

    logic [7:0] pat  [16];
    logic [7:0] got1 [16];
    logic [7:0] got0 [16];
    int nout1, nout0, ndone, span, sub_gap, sub_cnt, stall_err, rdy_err;
    logic rdy_at_done, post_done;

    // Drives pat[] in with in_valid gaps, drains with out_ready backpressure, records results.
    task automatic run_block(input int gap, input int bp);
        int li = 0;
        int c = 0;
        int c0 = -1;
        int c_last = -1;
        int c_busy = -1;
        int c1 = -1;
        logic prev_stall = 1'b0;
        logic [7:0] prev_dat = 8'h00;
        nout1 = 0; nout0 = 0; ndone = 0; sub_cnt = 0;
        stall_err = 0; rdy_err = 0; rdy_at_done = 1'b0;
        while (c < 3000 && c1 < 0) begin
            @(negedge clk);
            in_valid  = (li < 16) && (gap == 0 || $urandom_range(99) >= gap);
            in_data   = in_valid ? pat[li] : 8'($urandom_range(255));
            out_ready = (bp == 0 || $urandom_range(99) >= bp);
            #1;
            if (block_done) begin
                ndone++;
                c1 = c;
                rdy_at_done = in_ready;
            end
            if (busy && (in_ready || in_ready0)) rdy_err++;
            if (busy && c_busy < 0) c_busy = c;
            if (busy && !out_valid) sub_cnt++;
            if (prev_stall && out_data !== prev_dat) stall_err++;
            if (in_valid && in_ready) begin
                if (c0 < 0) c0 = c;
                c_last = c;
                li++;
            end
            if (out_valid && out_ready) begin
                if (nout1 < 16) got1[nout1] = out_data;
                nout1++;
            end
            if (out_valid0 && out_ready) begin
                if (nout0 < 16) got0[nout0] = out_data0;
                nout0++;
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = out_data;
            c++;
        end
        in_valid = 1'b0;
        span    = (c0 >= 0 && c1 >= 0) ? c1 - c0 : -1;
        sub_gap = (c_last >= 0 && c_busy >= 0) ? c_busy - c_last : -1;
        @(negedge clk);
        #1;
        post_done = block_done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        nassert++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || block_done !== 1'b0 ||
            sbox_in !== 8'h00 || out_data !== 8'h00) begin
            nfail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b done=%b sbox_in=%h out=%h, want 1 0 0 0 00 00",
                     in_ready, out_valid, busy, block_done, sbox_in, out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_block();
        for (int i = 0; i < 16; i++) pat[i] = 8'h00;
        run_block(0, 0);
        for (int i = 0; i < 16; i++) begin
            nassert++;
            if (got1[i] !== 8'h63) begin
                nfail++;
                $display("FAIL zero_out[%0d]: got %h want 63", i, got1[i]);
            end
        end
        nassert++;
        if (sub_gap !== 1) begin
            nfail++;
            $display("FAIL zero_sub_start: got %0d cycles after last accept, want 1", sub_gap);
        end
        nassert++;
        if (sub_cnt !== 16) begin
            nfail++;
            $display("FAIL zero_sub_len: got %0d want 16", sub_cnt);
        end
        nassert++;
        if (span !== 48) begin
            nfail++;
            $display("FAIL zero_span: got %0d want 48", span);
        end
        nassert++;
        if (ndone !== 1 || post_done !== 1'b0 || nout1 !== 16) begin
            nfail++;
            $display("FAIL zero_done_pulse: got done=%0d post=%b nout=%0d want 1 0 16", ndone, post_done, nout1);
        end
    endtask

    task automatic check_counting(input int gap, input int bp);
        logic [7:0] exp_sr [16];
        logic [7:0] exp_nat [16];
        exp_sr  = '{8'h63, 8'h6b, 8'h67, 8'h76, 8'hf2, 8'h01, 8'hab, 8'h7b,
                    8'h30, 8'hd7, 8'h77, 8'hc5, 8'hfe, 8'h7c, 8'h6f, 8'h2b};
        exp_nat = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
        for (int i = 0; i < 16; i++) pat[i] = 8'(i);
        run_block(gap, bp);
        for (int i = 0; i < 16; i++) begin
            nassert++;
            if (got1[i] !== exp_sr[i]) begin
                nfail++;
                $display("FAIL shiftrows_out[%0d] gap=%0d bp=%0d: got %h want %h", i, gap, bp, got1[i], exp_sr[i]);
            end
            nassert++;
            if (got0[i] !== exp_nat[i]) begin
                nfail++;
                $display("FAIL natural_out[%0d] gap=%0d bp=%0d: got %h want %h", i, gap, bp, got0[i], exp_nat[i]);
            end
        end
        nassert++;
        if (nout1 !== 16 || nout0 !== 16 || ndone !== 1) begin
            nfail++;
            $display("FAIL counting_count gap=%0d bp=%0d: got nout=%0d/%0d done=%0d want 16/16 1",
                     gap, bp, nout1, nout0, ndone);
        end
        nassert++;
        if (stall_err !== 0 || rdy_err !== 0) begin
            nfail++;
            $display("FAIL counting_stall gap=%0d bp=%0d: got stall_err=%0d rdy_err=%0d want 0 0",
                     gap, bp, stall_err, rdy_err);
        end
    endtask

    task automatic test_counting();
        check_counting(0, 0);
    endtask

    task automatic test_random_flow();
        check_counting(40, 50);
        check_counting(70, 80);
    endtask

    task automatic test_reset_mid_sub();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        repeat (16) @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        nassert++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL midsub_in_sub: got busy=%b vld=%b want 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        nassert++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sbox_in !== 8'h00) begin
            nfail++;
            $display("FAIL midsub_reset: got rdy=%b vld=%b busy=%b sbox_in=%h want 1 0 0 00",
                     in_ready, out_valid, busy, sbox_in);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) pat[i] = 8'hFF;
        run_block(20, 30);
        nassert++;
        if (nout1 !== 16 || nout0 !== 16) begin
            nfail++;
            $display("FAIL midsub_count: got %0d/%0d want 16/16", nout1, nout0);
        end
        for (int i = 0; i < 16; i++) begin
            nassert++;
            if (got1[i] !== 8'h16 || got0[i] !== 8'h16) begin
                nfail++;
                $display("FAIL midsub_out[%0d]: got %h/%h want 16", i, got1[i], got0[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int total_done;
        for (int i = 0; i < 16; i++) pat[i] = 8'h53;
        run_block(0, 0);
        total_done = ndone + (post_done ? 1 : 0);
        nassert++;
        if (rdy_at_done !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_ready_at_done: got %b want 1", rdy_at_done);
        end
        for (int i = 0; i < 16; i++) begin
            nassert++;
            if (got1[i] !== 8'hed) begin
                nfail++;
                $display("FAIL b2b_first[%0d]: got %h want ed", i, got1[i]);
            end
        end
        for (int i = 0; i < 16; i++) pat[i] = 8'h01;
        run_block(0, 0);
        total_done = total_done + ndone + (post_done ? 1 : 0);
        for (int i = 0; i < 16; i++) begin
            nassert++;
            if (got1[i] !== 8'h7c) begin
                nfail++;
                $display("FAIL b2b_second[%0d]: got %h want 7c", i, got1[i]);
            end
        end
        nassert++;
        if (total_done !== 2 || nout1 !== 16) begin
            nfail++;
            $display("FAIL b2b_done_count: got %0d pulses nout=%0d want 2 16", total_done, nout1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_zero_block();
        test_counting();
        test_random_flow();
        test_reset_mid_sub();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
